sha256_digest_uart_tx: RTL
==========================

# sha256_digest_uart_tx

Serializes a 256-bit SHA-256 digest into 32 bytes on an 8N1 UART line, most significant digest byte first. Sits at the output of the SHA-256 core inside the top-level design, accepting the finished hash over a valid/ready handshake and driving the serial `data_out` pin. It is the device-side transmitter that feeds the hash receiver on the host/bench side of the link.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- `DIGEST_BYTES`, 32, number of bytes sent per digest.
- `STOP_BITS`, 1, stop bits per byte; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; one clock domain, no other clocks.
- `digest_i`  in  8*DIGEST_BYTES  hash word; byte k = `digest_i[8*DIGEST_BYTES-1-8k -: 8]`.
- `digest_valid_i`  in  1  digest_i is valid.
- `digest_ready_o`  out  1  block can accept a digest.
- `data_out`  out  1  UART serial line, idle high.
- `busy_o`  out  1  transfer in progress.
- `done_o`  out  1  one-cycle pulse when the final stop bit has completed.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `data_out`=1, `digest_ready_o`=1, `busy_o`=0. On `digest_valid_i && digest_ready_o`, latch `digest_i` into an internal shift register, clear the byte index, go to START.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: drive bit `b` of the current byte, LSB first (b = 0..7), each for CLKS_PER_BIT cycles; after bit 7 go to STOP.
- STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles. Then, if the byte index < DIGEST_BYTES-1, increment it, shift to the next byte and go to START with no idle gap. Otherwise pulse `done_o` and go to IDLE.
- The latched copy is used for the whole transfer. Changes on `digest_i` or `digest_valid_i` while busy are ignored because `digest_ready_o`=0.
- Counters: the bit-time counter is `$clog2(CLKS_PER_BIT)` bits and counts 0..CLKS_PER_BIT-1. The bit index is 3 bits. The byte index is `$clog2(DIGEST_BYTES)` bits. No counter wraps outside its terminal compare.

## Timing
- Reset values: `data_out`=1, `digest_ready_o`=0 while `rst` is asserted and 1 from the first clock edge after deassertion, `busy_o`=0, `done_o`=0. The FSM resets to IDLE and all counters to 0.
- Reset mid-transfer: `data_out` goes high asynchronously and the transfer is aborted. No `done_o` pulse is produced and no partial resume occurs.
- Accept edge T: `digest_ready_o` and `busy_o` are registered. From T+1, `digest_ready_o`=0, `busy_o`=1, and `data_out`=0 (start bit).
- Each bit is held exactly CLKS_PER_BIT cycles.
- A byte takes (9+STOP_BITS)*CLKS_PER_BIT cycles. A digest takes DIGEST_BYTES*(9+STOP_BITS)*CLKS_PER_BIT cycles.
- `done_o` is high for exactly one cycle, on the cycle after the last stop-bit cycle. In that same cycle `digest_ready_o`=1 and `busy_o`=0.
- Back-to-back: if `digest_valid_i` is high during the `done_o` cycle, the new digest is accepted on that edge. The next start bit follows immediately, with no extra idle cycles.
- `data_out` is driven from a flop and is glitch-free.

## Test plan
- Reset check: hold `rst`=1 for 5 cycles, then release. `data_out`=1, `busy_o`=0 and `done_o`=0 throughout, and `digest_ready_o`=1 one cycle after release.
- Single digest, CLKS_PER_BIT=4: send digest 256'h5f806d26_1a579f2e_eea47739_6394699a_c2deaf34_2ec8da3b_189d8427_25a4a697.
  - Sample `data_out` mid-bit. Byte 0 must read as bits 0,1,1,1,1,1,0,1,0,1 (start, 0x5F LSB first, stop).
  - All 32 decoded bytes must equal 5f,80,…,a6,97 in order.
  - `done_o` must pulse once, 32*10*4=1280 cycles after the first start bit.
- Default timing, CLKS_PER_BIT=868: decode with a bench UART receiver sampling at 1.5 bit-periods after the falling edge. All 32 bytes must match the digest above, and each start bit must last exactly 8680 ns at a 10 ns clock.
- Input ignored while busy: change `digest_i` to all-ones and pulse `digest_valid_i` during byte 5. The transmitted stream must be unchanged, and `digest_ready_o` must stay 0 until `done_o`.
- Back-to-back: hold `digest_valid_i`=1 with a second digest of all 8'hA5 bytes. The second transfer's start bit must begin the cycle after `done_o`, and 32 bytes of 0xA5 must be decoded.
- Reset mid-byte: assert `rst` during the DATA bits of byte 10. `data_out` must go to 1 within the same cycle, with no `done_o` pulse. After release, a new digest must transmit correctly from byte 0.

Source files
------------

// File: rtl/sha256_digest_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sha256_digest_uart_tx : sends a 256-bit digest as 32 8N1 UART bytes, MSB byte first
// Rev 1.0
// ============================================================================
module sha256_digest_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DIGEST_BYTES = 32,
   parameter int STOP_BITS    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [8*DIGEST_BYTES-1:0] digest_i,
   input  logic                      digest_valid_i,
   output logic                      digest_ready_o,
   output logic                      data_out,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int DW    = 8*DIGEST_BYTES;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT-1);
   localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(DIGEST_BYTES-1);
   localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS-1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [IDX_W-1:0] byte_idx, byte_idx_n;
   logic [DW-1:0]    shreg, shreg_n;
   logic [7:0]       byte_n;
   logic             data_n, ready_n, busy_n, done_n;
   logic             bit_end;

   assign bit_end = (clk_cnt == LAST_CLK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         clk_cnt        <= '0;
         bit_idx        <= '0;
         byte_idx       <= '0;
         shreg          <= '0;
         data_out       <= 1'b1;
         digest_ready_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         state          <= state_n;
         clk_cnt        <= clk_cnt_n;
         bit_idx        <= bit_idx_n;
         byte_idx       <= byte_idx_n;
         shreg          <= shreg_n;
         data_out       <= data_n;
         digest_ready_o <= ready_n;
         busy_o         <= busy_n;
         done_o         <= done_n;
      end
   end

   // bit_idx doubles as the stop-bit counter while in STOP
   always_comb begin
      state_n    = state;
      clk_cnt_n  = clk_cnt;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      shreg_n    = shreg;
      if (state != IDLE) begin
         clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
      end
      case (state)
         IDLE: begin
            if (digest_valid_i && digest_ready_o) begin
               state_n    = START;
               shreg_n    = digest_i;
               byte_idx_n = '0;
               bit_idx_n  = '0;
               clk_cnt_n  = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_idx_n = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state_n   = STOP;
                  bit_idx_n = '0;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_idx == LAST_STOP) begin
                  bit_idx_n = '0;
                  if (byte_idx == LAST_BYTE) begin
                     state_n = IDLE;
                  end else begin
                     state_n    = START;
                     byte_idx_n = byte_idx + 1'b1;
                     shreg_n    = shreg << 8;
                  end
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are computed from the next state so every output comes straight from a flop
   always_comb begin
      byte_n  = shreg_n[DW-1 -: 8];
      data_n  = 1'b1;
      case (state_n)
         START:   data_n = 1'b0;
         DATA:    data_n = byte_n[bit_idx_n];
         default: data_n = 1'b1;
      endcase
      ready_n = (state_n == IDLE);
      busy_n  = (state_n != IDLE);
      done_n  = (state == STOP) && (state_n == IDLE);
   end

endmodule
`default_nettype wire
